abc_seq_gen: RTL and testbench



---
 rtl/abc_seq_pkg.sv | 21 ++
 rtl/abc_delay_pipe.sv | 53 +++++
 rtl/abc_seq_gen.sv | 158 +++++++++++++++
 tb/tb_abc_seq_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/abc_seq_pkg.sv
// ----------------------------------------------------------------------------
// abc_seq_pkg
// Shared definitions for the a/b/c three-phase pulse generator:
//   - abc_state_e    : burst FSM state encoding (IDLE, BURST, GAP)
//   - ABC_LEN_W      : default width of the burst length field
//   - ABC_GAP_W      : default width of the inter-burst gap field
//   - ABC_PIPE_DEPTH : number of delay stages behind `a` (b = 1, c = 2)
// ----------------------------------------------------------------------------
package abc_seq_pkg;

    localparam int ABC_LEN_W      = 8;
    localparam int ABC_GAP_W      = 4;
    localparam int ABC_PIPE_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } abc_state_e;

endpackage : abc_seq_pkg

// File: rtl/abc_delay_pipe.sv
// ----------------------------------------------------------------------------
// abc_delay_pipe
// Shift register that delays the phase-1 pulse to form the later phases, with
// a 1-bit tag travelling beside it that marks the last pulse of a burst.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset (clears data and tag stages)
//   a_i     in   phase-1 pulse entering the pipe
//   tag_i   in   set together with the last a_i of a burst
//   data_o  out  data taps, data_o[k] is a_i delayed by k+1 cycles
//   tag_o   out  tag delayed by DEPTH-1 cycles
//
// The tag chain is one stage shorter than the data chain: the consumer
// registers tag_o once more (merged with its other completion sources), so
// the resulting pulse lines up with the deepest data tap.
// ----------------------------------------------------------------------------
module abc_delay_pipe #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_i,
    input  logic             tag_i,
    output logic [DEPTH-1:0] data_o,
    output logic             tag_o
);

    logic [DEPTH-1:0] data_q;
    logic [DEPTH-2:0] tag_q;

    // Plain shift of data and tag; a reset discards anything in flight so a
    // cancelled burst leaves no trailing b/c pulses or completion tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            data_q[0] <= a_i;
            tag_q[0]  <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
            for (int i = 1; i < DEPTH - 1; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign data_o = data_q;
    assign tag_o  = tag_q[DEPTH-2];

endmodule : abc_delay_pipe

// File: rtl/abc_seq_gen.sv
// ----------------------------------------------------------------------------
// abc_seq_gen
// Driver side of the three-phase a/b/c pulse protocol. Accepts burst commands
// on a valid/ready handshake and emits `a` for cmd_len cycles, with `b` and
// `c` following one and two cycles later, then holds off for cmd_gap cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  generator can accept a command
//   cmd_len    in   number of `a` pulses in the burst (0 allowed)
//   cmd_gap    in   idle cycles forced after the last `a` of the burst
//   a          out  phase-1 pulse
//   b          out  phase-2 pulse (a delayed by 1)
//   c          out  phase-3 pulse (a delayed by 2)
//   done       out  one-cycle pulse marking burst completion
//   busy       out  FSM active or b/c pipeline non-empty
//
// All outputs come straight from flops; the output logic is computed from
// the FSM's next state so registered outputs still line up with the state.
// ----------------------------------------------------------------------------
module abc_seq_gen
    import abc_seq_pkg::*;
#(
    parameter int LEN_W = ABC_LEN_W,
    parameter int GAP_W = ABC_GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             done,
    output logic             busy
);

    abc_state_e state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic a_q, a_d;
    logic lastTag_q, lastTag_d;
    logic done_q, done_d;
    logic busy_q, busy_d;
    logic cmdReady_q, cmdReady_d;

    logic accept;
    logic zeroAccept;
    logic [ABC_PIPE_DEPTH-1:0] pipeData;
    logic pipeTag;

    // cmdReady_q is only ever set when the FSM is heading into IDLE, so it
    // alone qualifies the handshake.
    assign accept = cmd_valid && cmdReady_q;

    // State register: FSM state plus the remaining-length and gap counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic. BURST leaves while rem is 1, so rem counts down to 0
    // and never wraps; the gap counter likewise stops at 0 on its way out.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        zeroAccept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    gap_d = cmd_gap;
                    if (cmd_len != '0) begin
                        state_d = BURST;
                        rem_d   = cmd_len;
                    end else begin
                        zeroAccept = 1'b1;
                    end
                end
            end
            BURST: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = (gap_q != '0) ? GAP : IDLE;
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic, evaluated on the next state so that the registered
    // outputs appear in the same cycle the FSM is in that state. busy covers
    // the FSM plus whatever will still emerge as b or c on the next cycle.
    always_comb begin
        a_d        = (state_d == BURST);
        lastTag_d  = (state_d == BURST) && (rem_d == LEN_W'(1));
        done_d     = pipeTag || zeroAccept;
        busy_d     = (state_d != IDLE) || a_q || pipeData[0];
        cmdReady_d = (state_d == IDLE);
    end

    // Output registers; ready comes out of reset high so a command can be
    // taken on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= 1'b0;
            lastTag_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmdReady_q <= 1'b1;
        end else begin
            a_q        <= a_d;
            lastTag_q  <= lastTag_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cmdReady_q <= cmdReady_d;
        end
    end

    abc_delay_pipe #(
        .DEPTH (ABC_PIPE_DEPTH)
    ) u_delayPipe (
        .clk    (clk),
        .reset  (reset),
        .a_i    (a_q),
        .tag_i  (lastTag_q),
        .data_o (pipeData),
        .tag_o  (pipeTag)
    );

    assign a         = a_q;
    assign b         = pipeData[0];
    assign c         = pipeData[ABC_PIPE_DEPTH-1];
    assign done      = done_q;
    assign busy      = busy_q;
    assign cmd_ready = cmdReady_q;

endmodule : abc_seq_gen

// File: tb/tb_abc_seq_gen.sv
// ----------------------------------------------------------------------------
// tb_abc_seq_gen
// Directed bench for abc_seq_gen. Outputs are sampled on the falling edge as
// the vector {a, b, c, done, cmd_ready, busy}. For a command accepted at
// rising edge E, the value observed k cycles later is "the value at E+k".
// ----------------------------------------------------------------------------
module tb_abc_seq_gen;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic [3:0] cmd_gap;
    logic       a;
    logic       b;
    logic       c;
    logic       done;
    logic       busy;

    int vectorCount = 0;
    int missCount   = 0;

    abc_seq_gen #(
        .LEN_W (8),
        .GAP_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .a         (a),
        .b         (b),
        .c         (c),
        .done      (done),
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a wait is broken in a way the bounded loops miss.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, missCount=%0d", missCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] sampleOut();
        return {a, b, c, done, cmd_ready, busy};
    endfunction

    // Expected waveform for `bursts` commands of length n (n >= 1) and gap g,
    // issued with cmd_valid held so each one is taken as soon as ready rises.
    // Successive acceptances are p = n+1+g cycles apart.
    function automatic bit expA(int k, int n, int p, int bursts);
        return (k >= 1) && (((k - 1) / p) < bursts) && (((k - 1) % p) < n);
    endfunction

    function automatic bit expLastA(int k, int n, int p, int bursts);
        return expA(k, n, p, bursts) && (((k - 1) % p) == n - 1);
    endfunction

    function automatic bit expReady(int k, int p, int bursts);
        return ((k % p) == 0) || (k >= bursts * p);
    endfunction

    function automatic bit expBusy(int k, int n, int g, int p, int bursts);
        bit active;
        active = (k >= 1) && (((k - 1) / p) < bursts) && (((k - 1) % p) <= n + g - 1);
        return active || expA(k - 1, n, p, bursts) || expA(k - 2, n, p, bursts);
    endfunction

    // Waits (bounded) at a falling edge for cmd_ready; an expired bound shows
    // up as a miscompare on the ready check.
    task automatic waitReady(input string tag);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
    endtask

    // Issues `bursts` commands back to back by holding cmd_valid, and checks
    // every output cycle by cycle plus total a and done pulse counts.
    task automatic applyStimulus(input int n, input int g, input int bursts,
                                 input string tag);
        int p;
        int span;
        int aCnt = 0;
        int dCnt = 0;
        logic [5:0] obs;
        logic [5:0] expv;
        p    = n + 1 + g;
        span = bursts * p + 3;
        waitReady(tag);
        cmd_len   = 8'(n);
        cmd_gap   = 4'(g);
        cmd_valid = 1'b1;
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            obs  = sampleOut();
            expv = {expA(k, n, p, bursts), expA(k - 1, n, p, bursts),
                    expA(k - 2, n, p, bursts), expLastA(k - 2, n, p, bursts),
                    expReady(k, p, bursts), expBusy(k, n, g, p, bursts)};
            checkOutput($sformatf("%s_k%0d", tag, k), 32'(obs), 32'(expv));
            aCnt += int'(obs[5]);
            dCnt += int'(obs[2]);
            if (k == (bursts - 1) * p + 1) begin
                cmd_valid = 1'b0;
            end
        end
        checkOutput({tag, "_aCount"}, 32'(aCnt), 32'(n * bursts));
        checkOutput({tag, "_doneCount"}, 32'(dCnt), 32'(bursts));
    endtask

    initial begin
        $display("[TB] abc_seq_gen directed test start");
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 8'd3;
        cmd_gap   = 4'd0;

        // Reset with cmd_valid high: outputs idle, ready high, nothing taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_hold%0d", i), 32'(sampleOut()), 32'h02);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_release", 32'(sampleOut()), 32'h02);

        // Single short burst, no gap: ready back at E+4, done at E+5.
        applyStimulus(3, 0, 1, "len3gap0");

        // Two bursts with a 4-cycle gap, valid held: second accept at E+7.
        applyStimulus(2, 4, 2, "len2gap4");

        // Largest gap value.
        applyStimulus(1, 15, 2, "len1gap15");

        // Zero-length command: done one cycle later, no pulses, never busy.
        waitReady("len0");
        cmd_len   = 8'd0;
        cmd_gap   = 4'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("len0_k1", 32'(sampleOut()), 32'h06);
        @(negedge clk);
        checkOutput("len0_k2", 32'(sampleOut()), 32'h02);
        @(negedge clk);
        checkOutput("len0_k3", 32'(sampleOut()), 32'h02);

        // Reset in the middle of a len=5 burst discards everything in flight.
        waitReady("midrst");
        cmd_len   = 8'd5;
        cmd_gap   = 4'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_k1", 32'(sampleOut()), 32'h21);
        @(negedge clk);
        checkOutput("midrst_k2", 32'(sampleOut()), 32'h31);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_k3", 32'(sampleOut()), 32'h02);
        reset = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("midrst_k%0d", i), 32'(sampleOut()), 32'h02);
        end
        applyStimulus(1, 0, 1, "postrst");

        // Ten back-to-back single-pulse bursts, b/c overlapping the next a.
        applyStimulus(1, 0, 10, "b2b");

        // Maximum length: 255 a pulses, single done at E+257.
        applyStimulus(255, 0, 1, "len255");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule : tb_abc_seq_gen
